ddr_wr_arbiter: RTL

//  Shares one DDR write port among 4 video sampling channels. Each channel presents a ready burst from its

---
 rtl/ddr_wr_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ddr_wr_arbiter.sv
// Four-channel DDR write-port arbiter: emergency-first / round-robin grant,
// burst request, FIFO-to-DDR beat streaming and per-channel frame-region addressing.
module ddr_wr_arbiter #(
  parameter int unsigned DQ_WIDTH     = 32,
  parameter int unsigned ADDR_W       = 28,
  parameter int unsigned BURST_LEN    = 16,
  parameter int unsigned FRAME_BURSTS = 225,
  parameter int unsigned BASE_ADDR    = 0,
  parameter int unsigned REGION_BYTES = 32'h20000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              ch_ready,
  input  logic [15:0]             ch_id,
  input  logic [3:0]              ch_emergency,
  input  logic [3:0]              ch_frame_start,
  input  logic [4*DQ_WIDTH*8-1:0] ch_rd_data,
  output logic [3:0]              ch_rd_en,
  output logic                    ddr_wr_req,
  output logic [ADDR_W-1:0]       ddr_wr_addr,
  output logic [7:0]              ddr_wr_len,
  output logic [3:0]              ddr_wr_id,
  input  logic                    ddr_wr_ack,
  input  logic                    ddr_wdata_ready,
  output logic [DQ_WIDTH*8-1:0]   ddr_wdata,
  output logic                    ddr_wdata_valid,
  output logic                    ddr_wdata_last,
  input  logic                    ddr_wr_done,
  output logic                    busy
);

  localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);
  localparam int unsigned OFF_W = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_WAIT} state_t;

  state_t                     r_state, w_state_nxt;
  logic [1:0]                 r_grant, r_rr_ptr;
  logic [OFF_W-1:0]           r_off [4];
  logic [3:0]                 r_pend;
  logic [ADDR_W-1:0]          r_addr;
  logic [3:0]                 r_id;
  logic [7:0]                 r_len;
  logic [CNT_W-1:0]           r_issued;
  logic                       r_valid, r_last;

  logic [3:0][3:0]            w_ids;
  logic [3:0][DQ_WIDTH*8-1:0] w_rdata;
  logic [3:0]                 w_emerg;
  logic                       w_any, w_found, w_rd;
  logic [1:0]                 w_sel, w_idx;
  logic [OFF_W-1:0]           w_off_sel;
  logic [ADDR_W-1:0]          w_addr_nxt;

  assign w_ids   = ch_id;
  assign w_rdata = ch_rd_data;
  assign w_emerg = ch_ready & ch_emergency;
  assign w_any   = |ch_ready;

  always_comb begin
    w_sel   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    if (|w_emerg) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_emerg[2'(i)] && !w_found) begin
          w_sel   = 2'(i);
          w_found = 1'b1;
        end
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        w_idx = r_rr_ptr + 2'(i);
        if (ch_ready[w_idx] && !w_found) begin
          w_sel   = w_idx;
          w_found = 1'b1;
        end
      end
    end
  end

  // A frame-start pulse coinciding with the grant already counts for this burst.
  assign w_off_sel  = ch_frame_start[w_sel] ? '0 : r_off[w_sel];
  assign w_addr_nxt = ADDR_W'(BASE_ADDR)
                    + ADDR_W'(w_sel) * ADDR_W'(REGION_BYTES)
                    + ADDR_W'(w_off_sel) * ADDR_W'(BURST_LEN * DQ_WIDTH);

  assign w_rd = (r_state == S_DATA) && ddr_wdata_ready && (r_issued < CNT_W'(BURST_LEN));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_any)               w_state_nxt = S_REQ;
      S_REQ:  if (ddr_wr_ack)          w_state_nxt = S_DATA;
      S_DATA: if (r_valid && r_last)   w_state_nxt = S_WAIT;
      S_WAIT: if (ddr_wr_done)         w_state_nxt = S_IDLE;
      default:                         w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_pend   <= '0;
      r_addr   <= '0;
      r_id     <= '0;
      r_len    <= '0;
      r_issued <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) r_off[i] <= '0;
    end else begin
      if (r_state == S_IDLE && w_any) begin
        r_grant <= w_sel;
        r_addr  <= w_addr_nxt;
        r_id    <= w_ids[w_sel];
        r_len   <= 8'(BURST_LEN - 1);
      end

      if (r_state != S_DATA) r_issued <= '0;
      else if (w_rd)         r_issued <= r_issued + 1'b1;
      r_valid <= w_rd;
      r_last  <= w_rd && (r_issued == CNT_W'(BURST_LEN - 1));

      for (int unsigned i = 0; i < 4; i++) begin
        if (ch_frame_start[2'(i)]) begin
          if (r_state == S_IDLE || 2'(i) != r_grant) begin
            r_off[i]       <= '0;
            r_pend[2'(i)]  <= 1'b0;
          end else begin
            r_pend[2'(i)]  <= 1'b1;
          end
        end
      end

      // Completion overrides the pending-flag update above for the granted channel.
      if (r_state == S_WAIT && ddr_wr_done) begin
        if (r_off[r_grant] == OFF_W'(FRAME_BURSTS - 1) || r_pend[r_grant] ||
            ch_frame_start[r_grant])
          r_off[r_grant] <= '0;
        else
          r_off[r_grant] <= r_off[r_grant] + 1'b1;
        r_pend[r_grant] <= 1'b0;
        r_rr_ptr        <= r_grant + 2'd1;
      end
    end
  end

  assign ch_rd_en        = {3'b000, w_rd} << r_grant;
  assign ddr_wr_req      = (r_state == S_REQ);
  assign ddr_wr_addr     = r_addr;
  assign ddr_wr_len      = r_len;
  assign ddr_wr_id       = r_id;
  assign ddr_wdata       = r_valid ? w_rdata[r_grant] : '0;
  assign ddr_wdata_valid = r_valid;
  assign ddr_wdata_last  = r_valid && r_last;
  assign busy            = (r_state != S_IDLE);

endmodule
